// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared state encoding and sizing helper for the BCD converter
`timescale 1ns/1ps
package bcd_pkg;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Smallest number of decimal digits that can hold 2**width-1.
    // Only sensible for width below about 60.
    function automatic int bcd_digits(input int width);
        longint unsigned maxv;
        longint unsigned p;
        int              d;
        maxv = (64'd1 << width) - 64'd1;
        p    = 64'd10;
        d    = 1;
        for (int i = 0; i < 19; i++) begin
            if (p <= maxv) begin
                p = p * 64'd10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - combinational add-3 cell for one BCD digit
// Purpose: double-dabble digit correction applied before each shift.
// Ports:
//   digit_in  : current 4-bit BCD digit
//   digit_out : digit_in + 3 when digit_in is 5..9, digit_in when 0..4,
//               0 for the impossible codes 10..15
`timescale 1ns/1ps
module bcd_digit_adjust (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    always_comb begin
        digit_out = 4'd0;
        if (digit_in <= 4'd4) begin
            digit_out = digit_in;
        end else if (digit_in <= 4'd9) begin
            digit_out = digit_in + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_convert_sequencer.sv
// rtl/bcd_convert_sequencer.sv - sequential binary-to-BCD converter, one bit per clock
// Purpose: shift-and-add-3 conversion of bin_in with a start/busy/done handshake.
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : conversion request, honoured only in IDLE or DONE
//   bin_in  : unsigned operand, captured on the accepting edge
//   busy    : high while shifting
//   done    : one-cycle pulse when bcd_out has been updated
//   bcd_out : packed BCD result, digit 0 in bits [3:0], held between done pulses
`timescale 1ns/1ps
import bcd_pkg::*;

module bcd_convert_sequencer #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam int TW = BW + WIDTH;

    if (WIDTH < 2 || DIGITS < bcd_digits(WIDTH)) begin : g_param_check
        $error("bcd_convert_sequencer: DIGITS too small for WIDTH");
    end

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] work;       // {bcd digits, remaining binary bits}
    logic [BW-1:0] bcd_adj;
    logic [TW-1:0] work_next;

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_in  (work[WIDTH + 4*d +: 4]),
            .digit_out (bcd_adj[4*d +: 4])
        );
    end

    // Adjust first, then shift, all in one cycle. The value captured into
    // bcd_out after the last shift is never adjusted again.
    assign work_next = {bcd_adj[BW-2:0], work[WIDTH-1:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            work    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        work  <= {{BW{1'b0}}, bin_in};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    work <= work_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state   <= ST_DONE;
                        bcd_out <= work_next[TW-1:WIDTH];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_convert_sequencer.sv
// tb/tb_bcd_convert_sequencer.sv - self-checking bench for bcd_convert_sequencer
`timescale 1ns/1ps
module tb_bcd_convert_sequencer;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [WIDTH-1:0]  bin_in;
    logic              busy;
    logic              done;
    logic [11:0]       bcd_out;

    int n_cmp;
    int n_bad;

    bcd_convert_sequencer #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits from plain division
    function automatic logic [11:0] ref_bcd(input int v);
        logic [11:0] r;
        int          p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Continuous invariants, sampled on the falling edge
    logic [11:0] prev_bcd;
    logic        mon_en;
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("busy_and_done", {31'd0, busy & done}, 32'd0);
            if (!done) chk("bcd_hold", {20'd0, bcd_out}, {20'd0, prev_bcd});
        end
        prev_bcd = bcd_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done after an accepting edge already happened; returns edges taken
    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 30) begin
            tick();
            edges++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic convert(input int v, input string tag);
        int edges;
        int busy_cnt;
        start  = 1'b1;
        bin_in = WIDTH'(v);
        tick();
        start  = 1'b0;
        bin_in = WIDTH'($urandom);
        busy_cnt = 0;
        edges    = 0;
        while (!done && edges < 30) begin
            if (busy) busy_cnt++;
            tick();
            edges++;
        end
        chk({tag, "_latency"}, edges, WIDTH);
        chk({tag, "_busy_cycles"}, busy_cnt, WIDTH);
        chk({tag, "_bcd"}, {20'd0, bcd_out}, {20'd0, ref_bcd(v)});
        tick();
        chk({tag, "_done_width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int edges;
        int gap;
        n_cmp  = 0;
        n_bad  = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;

        // 1. reset and idle behaviour
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_bcd", {20'd0, bcd_out}, 32'd0);
        mon_en = 1'b1;
        bin_in = 8'd77;
        repeat (6) tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_bcd", {20'd0, bcd_out}, 32'd0);

        // 2. full-scale value
        convert(255, "max");

        // 3. directed, exhaustive sweep, random
        convert(0, "d0");
        convert(9, "d9");
        convert(10, "d10");
        convert(99, "d99");
        convert(128, "d128");
        for (int v = 0; v < 256; v++) convert(v, "sweep");
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            convert(int'($urandom_range(0, 255)), "rand");
        end

        // 4. start during SHIFT is ignored
        start  = 1'b1;
        bin_in = 8'd200;
        tick();
        start  = 1'b0;
        repeat (3) tick();
        start  = 1'b1;
        bin_in = 8'd7;
        tick();
        start  = 1'b0;
        wait_done(edges);
        chk("ignore_latency", edges, WIDTH - 4);
        chk("ignore_bcd", {20'd0, bcd_out}, 32'h200);
        tick();

        // 5. back-to-back with start held high
        start  = 1'b1;
        bin_in = 8'd1;
        tick();
        wait_done(edges);
        chk("b2b_first", {20'd0, bcd_out}, 32'h001);
        bin_in = 8'd42;
        tick();
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(gap);
        chk("b2b_gap", gap + 1, WIDTH + 1);
        chk("b2b_second", {20'd0, bcd_out}, 32'h042);
        start = 1'b0;
        tick();
        tick();
        chk("b2b_idle", {31'd0, busy}, 32'd0);

        // 6. abort mid-conversion
        start  = 1'b1;
        bin_in = 8'd123;
        tick();
        start  = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_bcd", {20'd0, bcd_out}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        edges = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done || busy) edges++;
        end
        chk("abort_no_done", edges, 0);
        convert(45, "post_abort");
        chk("post_abort_val", {20'd0, bcd_out}, 32'h045);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
